// File: rtl/seq_divider8.sv
// ----------------------------------------------------------------------------
// seq_divider8
//   Multi-cycle unsigned restoring divider for DIV-class instructions.
//   Operands are accepted on a start handshake. One quotient bit is resolved
//   per clock by trial subtraction. Results are returned with a one-cycle
//   done pulse.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; aborts any in-flight divide
//   start        request; operands are sampled when start=1 and busy=0
//   dividend     unsigned dividend (WIDTH bits)
//   divisor      unsigned divisor (WIDTH bits)
//   busy         high while a division is in progress
//   done         one-cycle pulse when the results are updated
//   quotient     result quotient, held until the next completion
//   remainder    result remainder, held until the next completion
//   div_by_zero  set with done when the divisor was 0, held until the next
//                completion
// ----------------------------------------------------------------------------
module seq_divider8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q;          // dividend shift register / quotient bits
  logic [WIDTH-1:0] d_q;          // latched divisor
  // Partial remainder. Its top bit is always 0 after a restoring step
  // (R < D), so only the low WIDTH bits are stored.
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   trial_t;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] r_d;

  // One restoring iteration: shift in the next dividend bit, trial-subtract
  // the divisor and keep the difference only if it did not go negative.
  always_comb begin
    trial_s = {r_q, q_q[WIDTH-1]};
    trial_t = trial_s - {1'b0, d_q};
    q_d     = {q_q[WIDTH-2:0], ~trial_t[WIDTH]};
    // When restoring, S < D <= 2^WIDTH-1, so S's top bit is 0 and can be dropped.
    r_d     = trial_t[WIDTH] ? trial_s[WIDTH-1:0] : trial_t[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            q_q     <= dividend;
            d_q     <= divisor;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (divisor == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            quotient_q  <= q_d;
            remainder_q <= r_d;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
        ZERO: begin
          quotient_q  <= '1;
          remainder_q <= q_q;
          dbz_q       <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider8.md
Name: seq_divider8

Overview:
- Multi-cycle unsigned restoring divider, the subtraction/division counterpart to the 8-bit ripple adder in the ALU datapath.
- Serves the DIV-class instructions of the 8086-style execution unit.
- Operands are accepted on a start handshake. One quotient bit is resolved per clock by trial subtraction.
- Quotient and remainder are returned with a one-cycle done pulse and a divide-by-zero flag.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; operands are sampled when start=1 and busy=0
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when results are valid/updated
- quotient  output  WIDTH  result quotient, held until next completion
- remainder  output  WIDTH  result remainder, held until next completion
- div_by_zero  output  1  set with done when divisor was 0, held until next completion

Behaviour:
- Interface decided: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (async assert, any state including mid-operation):
  - state=IDLE.
  - busy, done, div_by_zero, quotient, remainder, iteration counter and internal registers all cleared to 0.
  - An in-flight division is aborted, with no done pulse.
- States: IDLE, RUN, ZERO.
- IDLE:
  - On an edge with start=1, latch dividend into shift register Q and divisor into D, and clear partial remainder R (WIDTH+1 bits).
  - If divisor==0, go to ZERO; otherwise go to RUN with count=0.
  - busy=1 from that edge onward.
- RUN, each edge (one iteration):
  - Form S = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Compute T = S - {1'b0,D} at WIDTH+1 bits.
  - If T non-negative (MSB=0): R<=T and Q<={Q[WIDTH-2:0],1}.
  - Otherwise: R<=S and Q<={Q[WIDTH-2:0],0}.
  - count increments.
  - On the WIDTH-th iteration edge:
    - Write quotient<=final Q and remainder<=final R[WIDTH-1:0].
    - Set div_by_zero<=0, busy<=0, done<=1, and go to IDLE.
- ZERO, one edge:
  - Write quotient<=all ones, remainder<=latched dividend, div_by_zero<=1.
  - Set busy<=0, done<=1, and go to IDLE.
- Latency (start sampled at edge E0):
  - Normal divide: done/results visible after edge E(WIDTH), i.e. E8 for default.
  - Divide-by-zero: done/results visible after E1.
- done is high for exactly one cycle and is cleared on the following edge unless a new completion occurs.
- start while busy=1 is ignored (no effect on operands or timing). start need not be held.
- start in the cycle where done=1 (state IDLE) is accepted; back-to-back throughput is one division per WIDTH+1 cycles.
- Operand inputs are don't-care except at the accepting edge; changes during RUN do not affect the result.
- Invariant for divisor≠0: dividend = quotient*divisor + remainder, with remainder < divisor.
- Outputs quotient/remainder/div_by_zero change only at a completion edge or reset.

Test Plan:
- Reset, then dividend=100, divisor=7, start for 1 cycle -> busy=1 for 8 cycles; done pulse 8 edges after start; quotient=14, remainder=2, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0. 5/9 -> quotient=0, remainder=5. 200/200 -> quotient=1, remainder=0.
- 77/0 -> done 1 edge after start; div_by_zero=1, quotient=8'hFF, remainder=77. A following 9/3 clears the flag: quotient=3, remainder=0.
- Start 100/7, then pulse start with 50/5 mid-RUN -> second request ignored; result 14/2 at the original time, and busy never drops early.
- Start 100/7, assert rst_n=0 asynchronously at iteration 4 -> all outputs 0 immediately, no done pulse. After release, 9/4 -> quotient=2, remainder=1.
- Back-to-back: assert start with 60/8 in the done cycle of 100/7 -> accepted; second done 8 edges later with quotient=7, remainder=4.
- Random sweep of 1000 pairs (divisor≠0) -> check the invariant and the exact latency.
